// File: rtl/ts_packet_tx.sv
// MPEG transport-stream packetiser: emits 188-byte packets one byte per tx_en slot,
// filling with null packets when the source has nothing ready at a packet boundary.
module ts_packet_tx #(
  parameter logic [12:0] PID      = 13'h0100,
  parameter logic [12:0] NULL_PID = 13'h1FFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_en,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       null_pkt,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    HDR1    = 3'd2,
    HDR2    = 3'd3,
    HDR3    = 3'd4,
    PAYLOAD = 3'd5
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'd187;

  state_t      state_r, state_s;
  logic [7:0]  idx_r, idx_s;
  logic [3:0]  cc_r, cc_s;
  logic        null_r, null_s;
  logic [7:0]  byte_s;
  logic        valid_s, start_s, null_out_s, under_s;
  logic [12:0] pid_s;

  assign pl_ready = tx_en & (state_r == PAYLOAD) & ~null_r;
  assign pid_s    = null_r ? NULL_PID : PID;

  // Next-state and per-slot byte selection; IDLE with enable behaves as SYNC in the same slot.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cc_s       = cc_r;
    null_s     = null_r;
    byte_s     = 8'h00;
    valid_s    = 1'b0;
    start_s    = 1'b0;
    null_out_s = 1'b0;
    under_s    = 1'b0;
    if (tx_en) begin
      case (state_r)
        IDLE, SYNC: begin
          if ((state_r == SYNC) || enable) begin
            null_s     = ~pl_valid;
            null_out_s = ~pl_valid;
            byte_s     = 8'h47;
            valid_s    = 1'b1;
            start_s    = 1'b1;
            idx_s      = 8'd1;
            state_s    = HDR1;
          end else begin
            state_s = IDLE;
          end
        end
        HDR1: begin
          byte_s     = {3'b000, pid_s[12:8]};
          valid_s    = 1'b1;
          null_out_s = null_r;
          idx_s      = 8'd2;
          state_s    = HDR2;
        end
        HDR2: begin
          byte_s     = pid_s[7:0];
          valid_s    = 1'b1;
          null_out_s = null_r;
          idx_s      = 8'd3;
          state_s    = HDR3;
        end
        HDR3: begin
          byte_s     = {2'b00, 2'b01, (null_r ? 4'h0 : cc_r)};
          valid_s    = 1'b1;
          null_out_s = null_r;
          idx_s      = 8'd4;
          state_s    = PAYLOAD;
          if (!null_r) begin
            cc_s = cc_r + 4'd1;
          end else begin
            cc_s = cc_r;
          end
        end
        PAYLOAD: begin
          valid_s    = 1'b1;
          null_out_s = null_r;
          if (null_r) begin
            byte_s = 8'hFF;
          end else if (pl_valid) begin
            byte_s = pl_data;
          end else begin
            // source ran dry: stuff the slot so the packet keeps its length
            byte_s  = 8'hFF;
            under_s = 1'b1;
          end
          if (idx_r == LAST_IDX) begin
            idx_s   = 8'd0;
            state_s = enable ? SYNC : IDLE;
          end else begin
            idx_s   = idx_r + 8'd1;
            state_s = PAYLOAD;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      idx_r      <= 8'd0;
      cc_r       <= 4'd0;
      null_r     <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      pkt_start  <= 1'b0;
      null_pkt   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cc_r       <= cc_s;
      null_r     <= null_s;
      byte_out   <= byte_s;
      byte_valid <= valid_s;
      pkt_start  <= start_s;
      null_pkt   <= null_out_s;
      underrun   <= under_s;
    end
  end

endmodule

// File: tb/tb_ts_packet_tx.sv
// Randomized bench for ts_packet_tx against a position-counting packet model.
module tb_ts_packet_tx;

  logic       clk, rst, enable, tx_en, pl_valid, pl_ready;
  logic [7:0] pl_data, byte_out;
  logic       byte_valid, pkt_start, null_pkt, underrun;

  ts_packet_tx dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_en(tx_en),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_start(pkt_start),
    .null_pkt(null_pkt), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;
  int m_pos, m_cc;
  logic m_null;
  logic [11:0] e_out, obs;
  logic e_rdy, o_rdy;

  // {valid, start, null, underrun, byte}; byte only meaningful when valid
  assign obs = {byte_valid, pkt_start, null_pkt, underrun, (byte_valid ? byte_out : 8'h00)};

  task automatic model_reset();
    m_pos = -1; m_cc = 0; m_null = 1'b0;
  endtask

  // Reference: m_pos is the index of the next byte to send, -1 when not in a packet.
  task automatic model_slot();
    logic [12:0] pid;
    e_out = 12'h000;
    e_rdy = tx_en && (m_pos >= 4) && !m_null;
    if (tx_en) begin
      if (m_pos < 0 && enable) m_pos = 0;
      if (m_pos >= 0) begin
        if (m_pos == 0) m_null = !pl_valid;
        pid = m_null ? 13'h1FFF : 13'h0100;
        e_out[11] = 1'b1;
        e_out[9]  = m_null;
        if (m_pos == 0) begin
          e_out[10] = 1'b1; e_out[7:0] = 8'h47;
        end else if (m_pos == 1) e_out[7:0] = {3'b000, pid[12:8]};
        else if (m_pos == 2) e_out[7:0] = pid[7:0];
        else if (m_pos == 3) begin
          e_out[7:0] = 8'h10 + (m_null ? 8'd0 : 8'(m_cc));
          if (!m_null) m_cc = (m_cc + 1) % 16;
        end else if (m_null) e_out[7:0] = 8'hFF;
        else if (pl_valid) e_out[7:0] = pl_data;
        else begin
          e_out[7:0] = 8'hFF; e_out[8] = 1'b1;
        end
        m_pos++;
        if (m_pos == 188) m_pos = enable ? 0 : -1;
      end
    end
  endtask

  task automatic tick();
    #1;
    o_rdy = pl_ready;
    model_slot();
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; tx_en = 1'b0; pl_valid = 1'b0; pl_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({byte_out, byte_valid, pkt_start, null_pkt, underrun, pl_ready} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%b%b%b%b%b want 00/00000", byte_out, byte_valid, pkt_start, null_pkt, underrun, pl_ready);
    end
    @(negedge clk) rst = 1'b1;
    enable = 1'b1; tx_en = 1'b1; pl_valid = 1'b1; pl_data = 8'($urandom);
    tick();
    if (obs !== e_out) begin n_err++; $display("FAIL reset_model: got %h want %h", obs, e_out); end
    if (byte_out !== 8'h47 || pkt_start !== 1'b1) begin
      n_err++; $display("FAIL reset_first_byte: got %h start %b want 47 start 1", byte_out, pkt_start);
    end
  endtask

  task automatic test_stream();
    int pkt, p;
    logic [7:0] hdr;
    pkt = 0;
    for (int i = 0; i < 2 * 188 + 3; i++) begin
      p = m_pos;
      if (p == 0) pkt++;
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL stream: got %h want %h pos %0d", obs, e_out, p); end
      if (o_rdy !== e_rdy) begin n_err++; $display("FAIL stream_ready: got %b want %b pos %0d", o_rdy, e_rdy, p); end
      if (p >= 0 && p < 4) begin
        hdr = (p == 0) ? 8'h47 : (p == 1) ? 8'h01 : (p == 2) ? 8'h00 : 8'h10 + 8'(pkt);
        if (byte_out !== hdr) begin n_err++; $display("FAIL stream_hdr: got %h want %h pos %0d", byte_out, hdr, p); end
      end
    end
  endtask

  task automatic test_null();
    int st, p, n_null;
    logic [7:0] cc_a, cc_b;
    logic done;
    st = 0; n_null = 0; done = 1'b0; cc_a = 8'h00; cc_b = 8'h00;
    for (int i = 0; i < 900 && !done; i++) begin
      p = m_pos;
      pl_valid = 1'b1;
      pl_data = 8'($urandom);
      if (st == 1 && p == 0) begin pl_valid = 1'b0; st = 2; end
      else if (st == 2 && p == 0) st = 3;
      else if (st == 2) pl_valid = 1'($urandom_range(0, 1));
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL null: got %h want %h pos %0d", obs, e_out, p); end
      if (o_rdy !== e_rdy) begin n_err++; $display("FAIL null_ready: got %b want %b pos %0d", o_rdy, e_rdy, p); end
      if (st == 2) begin
        if (null_pkt) n_null++;
        if (o_rdy !== 1'b0) begin n_err++; $display("FAIL null_no_ready: got %b want 0 pos %0d", o_rdy, p); end
      end
      if (p == 3 && st == 0) begin cc_a = byte_out; st = 1; end
      else if (p == 3 && st == 3) begin cc_b = byte_out; done = 1'b1; end
    end
    if (!done) begin n_err++; $display("FAIL null_timeout: got stage %0d want 3", st); end
    if (cc_b !== {4'h1, cc_a[3:0] + 4'd1}) begin n_err++; $display("FAIL null_cc: got %h want %h", cc_b, {4'h1, cc_a[3:0] + 4'd1}); end
    if (n_null !== 188) begin n_err++; $display("FAIL null_count: got %0d want 188", n_null); end
  endtask

  task automatic test_underrun();
    int st, p, n_b, n_u;
    logic done;
    st = 0; n_b = 0; n_u = 0; done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      p = m_pos;
      if (st == 0 && p == 0) st = 1;
      else if (st == 1 && p == 0) st = 2;
      pl_valid = !(st == 1 && p >= 60 && p <= 62);
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL underrun: got %h want %h pos %0d", obs, e_out, p); end
      if (st == 1) begin
        if (byte_valid) n_b++;
        if (underrun) n_u++;
      end
      if (st == 2) begin
        if (pkt_start !== 1'b1 || byte_out !== 8'h47) begin
          n_err++; $display("FAIL underrun_next_sync: got %h start %b want 47 start 1", byte_out, pkt_start);
        end
        done = 1'b1;
      end
    end
    if (!done) begin n_err++; $display("FAIL underrun_timeout: got stage %0d want 2", st); end
    if (n_b !== 188) begin n_err++; $display("FAIL underrun_len: got %0d want 188", n_b); end
    if (n_u !== 3) begin n_err++; $display("FAIL underrun_pulses: got %0d want 3", n_u); end
  endtask

  task automatic test_toggle();
    logic prev;
    pl_valid = 1'b1;
    for (int i = 0; i < 4 * 188; i++) begin
      tx_en = (i % 2 == 0);
      prev = tx_en;
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL toggle: got %h want %h", obs, e_out); end
      if (o_rdy !== e_rdy) begin n_err++; $display("FAIL toggle_ready: got %b want %b", o_rdy, e_rdy); end
      if (byte_valid !== prev) begin n_err++; $display("FAIL toggle_valid: got %b want %b", byte_valid, prev); end
    end
    tx_en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      pl_valid = ($urandom_range(0, 7) != 0);
      pl_data = 8'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL random: got %h want %h", obs, e_out); end
      if (o_rdy !== e_rdy) begin n_err++; $display("FAIL random_ready: got %b want %b", o_rdy, e_rdy); end
    end
    enable = 1'b1; tx_en = 1'b1; pl_valid = 1'b1;
  endtask

  task automatic test_cc_sequence();
    int pk, p, idle;
    logic [7:0] want;
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    enable = 1'b1; tx_en = 1'b1; pl_valid = 1'b1;
    pk = 0; idle = 0;
    for (int i = 0; i < 17 * 188 + 400 && idle < 50; i++) begin
      p = m_pos;
      if (p == 0 || (p < 0 && enable)) pk++;
      if (pk == 17 && p == 100) enable = 1'b0;
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL cc_seq: got %h want %h pos %0d", obs, e_out, p); end
      if (p == 3) begin
        want = 8'h10 | 8'((pk - 1) % 16);
        if (byte_out !== want) begin n_err++; $display("FAIL cc_value: got %h want %h pkt %0d", byte_out, want, pk); end
      end
      if (pk == 17 && m_pos < 0 && p < 0) begin
        idle++;
        if (byte_valid !== 1'b0) begin n_err++; $display("FAIL cc_idle: got valid %b want 0", byte_valid); end
      end
    end
    if (pk !== 17 || idle !== 50) begin n_err++; $display("FAIL cc_packets: got %0d pkts %0d idle want 17 pkts 50 idle", pk, idle); end
  endtask

  task automatic test_reset_mid();
    logic done;
    enable = 1'b1; tx_en = 1'b1; pl_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL rstmid_pre: got %h want %h", obs, e_out); end
      if (m_pos == 50) done = 1'b1;
    end
    if (!done) begin n_err++; $display("FAIL rstmid_timeout: got pos %0d want 50", m_pos); end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({byte_out, byte_valid, pkt_start, null_pkt, underrun, pl_ready} !== 13'h0) begin
      n_err++;
      $display("FAIL rstmid_zero: got %h/%b%b%b%b%b want 00/00000", byte_out, byte_valid, pkt_start, null_pkt, underrun, pl_ready);
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pl_data = 8'($urandom);
      tick();
      if (obs !== e_out) begin n_err++; $display("FAIL rstmid_post: got %h want %h", obs, e_out); end
      if (i == 0 && (byte_out !== 8'h47 || pkt_start !== 1'b1)) begin
        n_err++; $display("FAIL rstmid_sync: got %h start %b want 47 start 1", byte_out, pkt_start);
      end
      if (i == 3 && byte_out !== 8'h10) begin
        n_err++; $display("FAIL rstmid_cc: got %h want 10", byte_out);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_stream();
    test_null();
    test_underrun();
    test_toggle();
    test_random();
    test_cc_sequence();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ts_packet_tx.md
TS_PACKET_TX -- requirements
Module: ts_packet_tx

Interface
REQ-001 Parameter PID, default 13'h0100, PID inserted into data packets.
REQ-002 Parameter NULL_PID, default 13'h1FFF, PID inserted into null packets.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  transmitter enable, sampled only at packet boundaries.
REQ-006 tx_en  input  1  byte-slot strobe; one output byte per cycle where tx_en=1.
REQ-007 pl_data  input  8  payload byte from source.
REQ-008 pl_valid  input  1  pl_data holds a valid byte.
REQ-009 pl_ready  output  1  combinational; source byte consumed this cycle when pl_ready=1.
REQ-010 byte_out  output  8  transmitted TS byte, registered.
REQ-011 byte_valid  output  1  byte_out valid this cycle, registered.
REQ-012 pkt_start  output  1  high with byte_valid on each 0x47 sync byte.
REQ-013 null_pkt  output  1  high with byte_valid for every byte of a null packet.
REQ-014 underrun  output  1  one-cycle pulse with the byte that was stuffed.

Function
REQ-015 Packet = 188 bytes: index 0 = 8'h47; 1 = {1'b0,1'b0,1'b0,pid[12:8]}; 2 = pid[7:0]; 3 = {2'b00,2'b01,cc[3:0]}; 4..187 = payload.
REQ-016 States IDLE, SYNC, HDR1, HDR2, HDR3, PAYLOAD; byte index counter 8 bits, 0..187.
REQ-017 IDLE: no output; on tx_en=1 with enable=1, go to SYNC processing in same slot (byte 0 emitted).
REQ-018 Packet type decided at the slot emitting byte 0: pl_valid=1 -> data packet, pl_valid=0 -> null packet; type held for whole packet.
REQ-019 SYNC->HDR1->HDR2->HDR3->PAYLOAD, one transition per tx_en=1 cycle; tx_en=0 holds state, counter, outputs deasserted.
REQ-020 PAYLOAD: advance per tx_en; after index 187, if enable=1 go to SYNC, else IDLE.
REQ-021 Byte emitted at index 187 is followed back-to-back by next sync on the next tx_en slot (no gap).
REQ-022 Output latency: byte for slot at cycle N appears on byte_out/byte_valid at cycle N+1; byte_valid=1 exactly one cycle per tx_en slot consumed.
REQ-023 pl_ready = tx_en & (state==PAYLOAD) & data packet; never asserted in header or null packet slots.
REQ-024 Data payload slot with pl_valid=1: byte_out=pl_data.
REQ-025 Data payload slot with pl_valid=0: byte_out=8'hFF, underrun=1 that cycle, counter still advances, packet length unchanged.
REQ-026 Null packet: PID=NULL_PID, cc field 4'h0, payload bytes 8'hFF, pl_data never consumed.
REQ-027 cc: 4-bit, used in byte 3 of data packets, increments after each data packet's byte 3 is emitted, wraps 15->0; null packets do not change it.
REQ-028 enable deassertion mid-packet does not truncate; current packet completes all 188 bytes.
REQ-029 First data packet after reset carries cc=0.

Reset
REQ-030 rst=0 at any time: state=IDLE, counter=0, cc=0, byte_out=8'h00, byte_valid=0, pkt_start=0, null_pkt=0, underrun=0; partial packet discarded.
REQ-031 After rst release, first byte emitted is always 8'h47 with pkt_start=1.

Verification
REQ-032 enable=1, tx_en=1 always, pl_valid=1 always -> bytes 47 01 00 10, 184 source bytes, then 47 01 00 11; pkt_start every 188 bytes.
REQ-033 pl_valid=0 at packet start -> 47 1F FF 10, 184×FF, null_pkt=1 all 188 bytes, pl_ready never high, next data packet cc unchanged.
REQ-034 pl_valid drops for 3 payload slots -> three FF bytes with underrun pulses, packet still 188 bytes, following sync on time.
REQ-035 tx_en toggled 1/0 alternately -> byte_valid every other cycle, content identical to REQ-032 stream.
REQ-036 Send 17 data packets -> cc sequence 0..15,0; enable dropped at byte 100 -> packet completes, then IDLE, no further byte_valid.
REQ-037 rst asserted at byte 50 -> outputs zero immediately; after release first byte 47 with cc=0.
